// File: rtl/esc_seq_tx.sv
// esc_seq_tx: serialises editing/key commands into VT100/ANSI byte sequences.
// Optional build macro ESC_TX_DESTRUCTIVE_BS_EN: BACKSPACE emits 08 20 08.
module esc_seq_tx #(
   parameter int unsigned GAP_CYCLES  = 0,
   parameter logic [7:0]  LEFT_FINAL  = 8'h44,
   parameter logic [7:0]  RIGHT_FINAL = 8'h43
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [2:0] cmd_op,
   input  logic [7:0] cmd_char,
   output logic [7:0] tx_data,
   output logic       tx_valid,
   input  logic       tx_ready,
   output logic       busy,
   output logic       seq_done
);

   typedef enum logic [1:0] {
      IDLE,
      SEND,
      GAP,
      DONE
   } state_t;

   localparam logic [2:0] OP_CHAR  = 3'd0;
   localparam logic [2:0] OP_LEFT  = 3'd1;
   localparam logic [2:0] OP_RIGHT = 3'd2;
   localparam logic [2:0] OP_DEL   = 3'd3;
   localparam logic [2:0] OP_BS    = 3'd4;
   localparam logic [2:0] OP_ENTER = 3'd5;
   localparam logic [2:0] OP_SPACE = 3'd6;
   localparam logic [2:0] OP_RSV   = 3'd7;

   // last gap-counter value before returning to SEND
   localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);

   state_t     state;
   state_t     state_nx;
   logic [2:0] op;
   logic [7:0] ch;
   logic [1:0] idx;
   logic [1:0] last;
   logic [7:0] gap_cnt;
   logic       accept;
   logic       hs;

   // byte at position i of the sequence for op o
   function automatic logic [7:0] seq_byte(
      input logic [2:0] o,
      input logic [7:0] c,
      input logic [1:0] i
   );
      seq_byte = 8'h00;
      case (o)
         OP_CHAR: seq_byte = c;
         OP_LEFT, OP_RIGHT: begin
            case (i)
               2'd0:    seq_byte = 8'h1B;
               2'd1:    seq_byte = 8'h5B;
               default: seq_byte = (o == OP_LEFT) ? LEFT_FINAL : RIGHT_FINAL;
            endcase
         end
         OP_DEL: begin
            case (i)
               2'd0:    seq_byte = 8'h1B;
               2'd1:    seq_byte = 8'h5B;
               2'd2:    seq_byte = 8'h33;
               default: seq_byte = 8'h7E;
            endcase
         end
`ifdef ESC_TX_DESTRUCTIVE_BS_EN
         OP_BS:    seq_byte = (i == 2'd1) ? 8'h20 : 8'h08;
`else
         OP_BS:    seq_byte = 8'h08;
`endif
         OP_ENTER: seq_byte = 8'h0D;
         OP_SPACE: seq_byte = 8'h20;
         default:  seq_byte = 8'h00;
      endcase
   endfunction

   // index of the final byte for op o
   function automatic logic [1:0] seq_last(input logic [2:0] o);
      seq_last = 2'd0;
      case (o)
         OP_LEFT, OP_RIGHT: seq_last = 2'd2;
         OP_DEL:            seq_last = 2'd3;
`ifdef ESC_TX_DESTRUCTIVE_BS_EN
         OP_BS:             seq_last = 2'd2;
`endif
         default:           seq_last = 2'd0;
      endcase
   endfunction

   assign last = seq_last(op);

   // state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   // next state and handshake outputs
   always_comb begin
      state_nx  = state;
      cmd_ready = 1'b0;
      tx_valid  = 1'b0;
      busy      = 1'b1;
      seq_done  = 1'b0;
      accept    = 1'b0;
      hs        = 1'b0;
      case (state)
         IDLE: begin
            busy      = 1'b0;
            cmd_ready = !reset;
            accept    = cmd_valid && !reset;
            if (accept)
               state_nx = (cmd_op == OP_RSV) ? DONE : SEND;
         end
         SEND: begin
            tx_valid = 1'b1;
            hs       = tx_ready;
            if (hs) begin
               if (idx == last)            state_nx = DONE;
               else if (GAP_CYCLES != 0)   state_nx = GAP;
               else                        state_nx = SEND;
            end
         end
         GAP: begin
            if (gap_cnt == GAP_LAST) state_nx = SEND;
         end
         DONE: begin
            seq_done = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // command latch, byte index, gap counter and registered tx byte
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         op      <= 3'd0;
         ch      <= 8'h00;
         idx     <= 2'd0;
         gap_cnt <= 8'h00;
         tx_data <= 8'h00;
      end else begin
         if (accept) begin
            op      <= cmd_op;
            ch      <= cmd_char;
            idx     <= 2'd0;
            tx_data <= seq_byte(cmd_op, cmd_char, 2'd0);
         end else if (hs && idx != last) begin
            idx     <= idx + 2'd1;
            tx_data <= seq_byte(op, ch, idx + 2'd1);
         end
         if (state == GAP) gap_cnt <= gap_cnt + 8'd1;
         else              gap_cnt <= 8'h00;
      end
   end

endmodule
